ap_ctrl_sequencer: RTL

Synthesizable initiator for the Vitis HLS block-level control handshake: it drives `ap_start`/`ap_continue` into a kernel and consumes `ap_ready`/`ap_done`, issuing a programmed number of transactions with bounded overlap. It sits in the cosim testbench between the transaction generator and `AESL_inst_*`. It is the driving end of the handshake that the dataflow monitors observe. It also reports per-transaction latency and start interval, so the module-status CSVs can be cross-checked in hardware.

---
 rtl/ap_ctrl_sequencer.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/ap_ctrl_sequencer.sv
// Initiator for the HLS ap_ctrl block-level handshake with latency/interval reporting.
// Define AP_CTRL_CHAIN_EN to drive ap_continue from continue_hold (ap_ctrl_chain).
module ap_ctrl_sequencer #(
   parameter int unsigned CNT_W        = 32,
   parameter int unsigned MAX_INFLIGHT = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             go,
   input  logic [CNT_W-1:0] num_trans,
   input  logic             continue_hold,
   output logic             ap_start,
   input  logic             ap_ready,
   input  logic             ap_done,
   output logic             ap_continue,
   output logic             busy,
   output logic             finish,
   output logic [CNT_W-1:0] issued,
   output logic [CNT_W-1:0] completed,
   output logic [CNT_W-1:0] latency_last,
   output logic [CNT_W-1:0] interval_last,
   output logic             error
);

   localparam int unsigned PtrW = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;
   localparam int unsigned OccW = $clog2(MAX_INFLIGHT + 1);
   localparam logic [OccW-1:0] OccMax = OccW'(MAX_INFLIGHT);

   typedef enum logic [1:0] {StIdle, StRun, StDrain, StFinish} state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cycle_cnt_q;
   logic [CNT_W-1:0] n_q, n_d;
   logic [CNT_W-1:0] issued_q, issued_d;
   logic [CNT_W-1:0] completed_q, completed_d;
   logic [CNT_W-1:0] lat_q, lat_d;
   logic [CNT_W-1:0] int_q, int_d;
   logic [CNT_W-1:0] last_acc_q, last_acc_d;
   logic             start_q, start_d;
   logic             err_q, err_d;
   logic             seen_q, seen_d;
   logic [CNT_W-1:0] ts_mem [MAX_INFLIGHT];
   logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [OccW-1:0]  count_q, count_d;

   logic             active, acc, cmp, fifo_empty, pop, cmp_same, spurious;
   logic             push, overflow, do_push;
   logic [CNT_W-1:0] issued_nx, completed_nx;
   logic [OccW-1:0]  count_nx;

   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      return (p == PtrW'(MAX_INFLIGHT - 1)) ? '0 : p + 1'b1;
   endfunction

`ifdef AP_CTRL_CHAIN_EN
   assign ap_continue = ~continue_hold;
`else
   logic unused_hold;
   assign unused_hold = continue_hold;
   assign ap_continue = 1'b1;
`endif

   assign active     = (state_q == StRun) || (state_q == StDrain);
   assign acc        = start_q & ap_ready;
   assign cmp        = ap_done & ap_continue & active;
   assign fifo_empty = (count_q == '0);
   assign pop        = cmp & ~fifo_empty;
   // A done against an empty FIFO pairs with the accept of the same cycle.
   assign cmp_same   = cmp & fifo_empty & acc;
   assign spurious   = cmp & fifo_empty & ~acc;
   assign push       = acc & ~cmp_same;
   assign overflow   = push & ~pop & (count_q == OccMax);
   assign do_push    = push & ~overflow;

   assign issued_nx    = issued_q + CNT_W'(acc);
   assign completed_nx = completed_q + CNT_W'(pop | cmp_same);
   assign count_nx     = count_q + OccW'(do_push) - OccW'(pop);

   always_comb begin
      state_d     = state_q;
      n_d         = n_q;
      issued_d    = issued_q;
      completed_d = completed_q;
      lat_d       = lat_q;
      int_d       = int_q;
      last_acc_d  = last_acc_q;
      start_d     = start_q;
      err_d       = err_q;
      seen_d      = seen_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      unique case (state_q)
         StIdle: begin
            if (go) begin
               n_d         = num_trans;
               issued_d    = '0;
               completed_d = '0;
               err_d       = 1'b0;
               seen_d      = 1'b0;
               wr_ptr_d    = '0;
               rd_ptr_d    = '0;
               count_d     = '0;
               start_d     = (num_trans != '0);
               state_d     = (num_trans != '0) ? StRun : StFinish;
            end
         end
         StRun, StDrain: begin
            issued_d    = issued_nx;
            completed_d = completed_nx;
            count_d     = count_nx;
            err_d       = err_q | spurious | overflow;
            if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (pop) begin
               rd_ptr_d = ptr_inc(rd_ptr_q);
               lat_d    = cycle_cnt_q - ts_mem[rd_ptr_q];
            end else if (cmp_same) begin
               lat_d = '0;
            end
            if (acc) begin
               if (seen_q) int_d = cycle_cnt_q - last_acc_q;
               last_acc_d = cycle_cnt_q;
               seen_d     = 1'b1;
            end
            // Held until ready is sampled, otherwise re-armed from post-event counts.
            start_d = (start_q & ~ap_ready) |
                      ((state_q == StRun) & (issued_nx < n_q) & (count_nx < OccMax));
            if (state_q == StRun && issued_nx == n_q) begin
               state_d = (completed_nx == n_q) ? StFinish : StDrain;
            end else if (state_q == StDrain && completed_nx == n_q) begin
               state_d = StFinish;
            end
         end
         StFinish: state_d = StIdle;
         default:  state_d = StIdle;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q     <= StIdle;
         cycle_cnt_q <= '0;
         n_q         <= '0;
         issued_q    <= '0;
         completed_q <= '0;
         lat_q       <= '0;
         int_q       <= '0;
         last_acc_q  <= '0;
         start_q     <= 1'b0;
         err_q       <= 1'b0;
         seen_q      <= 1'b0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
      end else begin
         state_q     <= state_d;
         cycle_cnt_q <= cycle_cnt_q + 1'b1;
         n_q         <= n_d;
         issued_q    <= issued_d;
         completed_q <= completed_d;
         lat_q       <= lat_d;
         int_q       <= int_d;
         last_acc_q  <= last_acc_d;
         start_q     <= start_d;
         err_q       <= err_d;
         seen_q      <= seen_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
      end
   end

   always_ff @(posedge clock) begin
      if (do_push) ts_mem[wr_ptr_q] <= cycle_cnt_q;
   end

   assign ap_start      = start_q;
   assign busy          = active;
   assign finish        = (state_q == StFinish);
   assign issued        = issued_q;
   assign completed     = completed_q;
   assign latency_last  = lat_q;
   assign interval_last = int_q;
   assign error         = err_q;

endmodule
